// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MDU_MUL   = 3'b000,
        MDU_MULH  = 3'b001,
        MDU_MULHU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_REM   = 3'b101,
        MDU_REMU  = 3'b110,
        MDU_RSVD  = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_e;

    function automatic logic op_signed(mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_is_div(mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction
endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result selection applied in the FIX state.
module mdu_sign_fix import mdu_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  mdu_op_e         op,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic            b_zero,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] a_orig,
    output logic [XLEN-1:0] res
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        prod = (sign_a ^ sign_b) ? -{hi, lo} : {hi, lo};
        quot = (sign_a ^ sign_b) ? -lo : lo;
        rem  = sign_a ? -hi : hi;
        // divide-by-zero bypasses sign correction entirely
        unique case (op)
            MDU_MUL:           res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHU: res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU: res = b_zero ? '1 : quot;
            MDU_REM, MDU_REMU: res = b_zero ? a_orig : rem;
            default:           res = '0;
        endcase
    end
endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply, restoring divide on
// operand magnitudes, sign fixed up in a final cycle.
module mdu_iterative import mdu_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    mdu_state_e      state;
    mdu_op_e         op_q;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] a_q, b_q, mag, hi, lo;
    logic            sign_a, sign_b;

    mdu_op_e         op_in;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] ma_in, mb_in, hi_nxt, lo_nxt, fix_res;
    logic [XLEN:0]   sum, shifted, diff;

    always_comb begin
        op_in = mdu_op_e'(op);
        sa_in = op_signed(op_in) & A[XLEN-1];
        sb_in = op_signed(op_in) & B[XLEN-1];
        ma_in = sa_in ? -A : A;
        mb_in = sb_in ? -B : B;
    end

    // mul: hi:lo is partial product : remaining multiplier, mag = multiplicand
    // div: hi:lo is partial remainder : remaining dividend/quotient, mag = divisor
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, mag};
        hi_nxt  = sum[XLEN:1];
        lo_nxt  = {sum[0], lo[XLEN-1:1]};
        if (op_is_div(op_q)) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    mdu_sign_fix #(.XLEN(XLEN)) u_fix (
        .op     (op_q),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .b_zero (b_q == '0),
        .hi     (hi),
        .lo     (lo),
        .a_orig (a_q),
        .res    (fix_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= MDU_MUL;
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mag    <= '0;
            hi     <= '0;
            lo     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        op_q   <= op_in;
                        a_q    <= A;
                        b_q    <= B;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        mag    <= op_is_div(op_in) ? mb_in : ma_in;
                        lo     <= op_is_div(op_in) ? ma_in : mb_in;
                        hi     <= '0;
                        count  <= '0;
                    end
                    CALC: begin
                        hi    <= hi_nxt;
                        lo    <= lo_nxt;
                        count <= count + 1'b1;
                        if (count == CW'(XLEN-1)) state <= FIX;
                    end
                    FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed vectors, result and latency checked.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B, result;
    logic        busy, done;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    string       name_q[$];

    mdu_iterative #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                string nm;
                int    c;
                logic [31:0] e;
                e  = exp_q.pop_front();
                c  = cyc_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, result, e);
                chk({nm, "_latency"}, cyc, c);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string nm, input bit track);
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
        start = 1'b1; op = o; A = a; B = b;
        if (track) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 34);
            name_q.push_back(nm);
        end
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; A = '0; B = '0;
        #1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_done", done, 32'd0);
        chk("reset_result", result, 32'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // MUL with a stray start mid-flight; busy must last exactly 33 cycles
        issue(3'b000, 32'd7, 32'd6, 32'd42, "mul_7x6", 1'b1);
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            if (nb == 5) begin start = 1'b1; op = 3'b100; A = 32'd1; B = 32'd1; end
            @(negedge clk);
            start = 1'b0;
            nb++;
        end
        chk("busy_cycles", nb, 32'd33);
        drain();
        repeat (40) @(negedge clk);

        // back-to-back issue lands each start in the previous done cycle
        issue(3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, "mulh_m2x3",    1'b1);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max",    1'b1);
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1xm1",    1'b1);
        issue(3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2",     1'b1);
        issue(3'b101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2",     1'b1);
        issue(3'b100, 32'd100,      32'd7,        32'd14,       "divu_100_7",   1'b1);
        issue(3'b110, 32'd100,      32'd7,        32'd2,        "remu_100_7",   1'b1);
        issue(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0",     1'b1);
        issue(3'b101, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "rem_by0",      1'b1);
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf",      1'b1);
        issue(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf",      1'b1);
        issue(3'b111, 32'd12,       32'd34,       32'h00000000, "reserved",     1'b1);
        issue(3'b000, 32'd7,        32'd6,        32'd42,       "mul_7x6_again", 1'b1);
        drain();

        // flush at CALC cycle 10: no done, result held
        issue(3'b000, 32'd3, 32'd5, 32'd0, "flushed", 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 32'd0);
        chk("flush_done", done, 32'd0);
        chk("flush_result", result, 32'd42);
        repeat (40) @(negedge clk);
        chk("flush_result_held", result, 32'd42);
        issue(3'b000, 32'd3, 32'd5, 32'd15, "mul_after_flush", 1'b1);
        drain();

        // asynchronous reset in the middle of CALC
        issue(3'b011, 32'hFFFFFFF9, 32'd2, 32'd0, "reset_victim", 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 32'd0);
        chk("midreset_done", done, 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        issue(3'b100, 32'd9, 32'd3, 32'd3, "divu_9_3", 1'b1);
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit (RV32M subset) in the execute stage, beside the combinational ALU.
- Takes the same A/B operands as the ALU. Its result is muxed with ALUResult into writeback.
- Control holds the instruction until done.
- Uses shift-add multiplication and restoring division on operand magnitudes, with sign correction at the end.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  000 MUL, 001 MULH, 010 MULHU, 011 DIV, 100 DIVU, 101 REM, 110 REMU, 111 reserved
- A  in  XLEN  operand rs1 (dividend / multiplicand)
- B  in  XLEN  operand rs2 (divisor / multiplier)
- flush  in  1  abort in-flight operation
- busy  out  1  high from the accepted start until the done cycle (exclusive)
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  registered result, held until the next accepted start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States:
  - IDLE: start=1 latches op, A, B, the sign flags and the operand magnitudes; count=0; goes to CALC. done deasserts on any edge.
  - CALC: one multiply or divide step per cycle; count increments; after XLEN steps goes to FIX.
  - FIX: sign correction and selection; result registered; done=1 for the next cycle; returns to IDLE.
- Latency: start sampled at edge E gives done=1 and a valid result in the cycle following edge E+XLEN+1 (33 for XLEN=32). Latency is fixed for every op, including divide-by-zero and reserved.
- Signedness:
  - MUL and MULH treat both operands as signed.
  - MULHU, DIVU and REMU treat both as unsigned.
  - DIV and REM treat both as signed.
- Multiply: 2*XLEN-bit product. MUL returns the low XLEN bits; MULH and MULHU return the high XLEN bits.
- Product sign correction: negate the 2*XLEN-bit product when the operand signs differ.
- Division rounds toward zero:
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Divide by zero (B=0), checked in FIX with sign correction suppressed:
  - DIV/DIVU return all-ones.
  - REM/REMU return the original A.
- Signed overflow (A=0x80000000, B=-1): DIV returns 0x80000000 and REM returns 0. This falls out of magnitude arithmetic; no special case.
- op=111: result=0 with normal latency.
- start while busy=1: ignored, no queueing.
- start in the same cycle done=1: accepted, since state is IDLE.
- flush=1 in CALC or FIX:
  - Next state IDLE, busy=0, no done.
  - result keeps its previous value.
  - flush has priority over start and over FIX completion.
- Reset mid-operation: immediate return to the reset values.
- A and B changing after acceptance have no effect.

Decomposition:
- Package mdu_pkg:
  - op encodings (MDU_MUL … MDU_REMU, MDU_RSVD).
  - state enum (IDLE, CALC, FIX).
  - XLEN default constant.
- No sub-module is required. An optional combinational mdu_sign_fix (negation and selection logic used in FIX) is acceptable.

Test Plan:
- MUL A=7, B=6: busy=1 for 33 cycles, then done pulse with result=42. A second start issued while busy is ignored.
- MULH A=-2, B=3 gives 0xFFFFFFFF. MULHU A=B=0xFFFFFFFF gives 0xFFFFFFFE. MUL A=B=0xFFFFFFFF gives 0x00000001.
- DIV A=-7, B=2 gives 0xFFFFFFFD. REM A=-7, B=2 gives 0xFFFFFFFF. DIVU A=100, B=7 gives 14. REMU A=100, B=7 gives 2.
- DIVU A=5, B=0 gives 0xFFFFFFFF. REM A=-5, B=0 gives 0xFFFFFFFB. DIV A=0x80000000, B=-1 gives 0x80000000. REM of the same operands gives 0.
- flush at CALC cycle 10 after a MUL that previously gave 42: no done, busy=0 next cycle, result stays 42. A new start then completes normally.
- rst_n low at CALC cycle 20: busy, done and result go to 0 asynchronously. After release, a start with DIVU A=9, B=3 returns 3 after 33 cycles.
